// File: rtl/sram_wb_ctrl.sv
// Wishbone classic slave: 32-bit access as two 16-bit async SRAM cycles; read ack 2*(W+1)+1, write 2*(W+2)+1 cycles.
// One request at a time, wb_ack_o is the only stall signal; define SRAM_CTRL_SKIP_HALF_EN to skip unselected write halves.
module sram_wb_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic [17:0] sram_a_o,
  inout  wire  [15:0] sram_io,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_we_n_o,
  output logic        sram_lb_n_o,
  output logic        sram_ub_n_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_WSETUP = 3'd2;
  localparam logic [2:0] S_WPULSE = 3'd3;
  localparam logic [2:0] S_WHOLD  = 3'd4;
  localparam logic [2:0] S_ACK    = 3'd5;

  localparam logic [3:0] RD_LAST = 4'(WAIT_CYCLES);
  localparam logic [3:0] WP_LAST = 4'(WAIT_CYCLES - 1);

  logic [2:0]  state, nxt_state;
  logic        half, nxt_half;
  logic [3:0]  cnt, nxt_cnt;
  logic        abort, abort_any;
  logic [16:0] adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic        drive;
  logic [15:0] dout;

  logic        req;
  logic [16:0] cur_adr;
  logic [31:0] cur_dat;
  logic [3:0]  cur_sel;
  logic [1:0]  nxt_lanes;
  logic [15:0] nxt_wdat;
  logic        nxt_wr;
  logic        enter_acc;
  logic        rd_done;
  logic        second_wr;
  logic        unused_adr;

  assign unused_adr = ^{wb_adr_i[31:19], wb_adr_i[1:0]};

  assign req = wb_cyc_i & wb_stb_i;

  // In IDLE the request is still on the bus; afterwards use the latched copy.
  assign cur_adr = (state == S_IDLE) ? wb_adr_i[18:2] : adr_q;
  assign cur_dat = (state == S_IDLE) ? wb_dat_i       : dat_q;
  assign cur_sel = (state == S_IDLE) ? wb_sel_i       : sel_q;

  assign nxt_lanes = nxt_half ? cur_sel[1:0] : cur_sel[3:2];
  assign nxt_wdat  = nxt_half ? cur_dat[15:0] : cur_dat[31:16];

  assign rd_done = (state == S_RD) && (cnt == RD_LAST);

`ifdef SRAM_CTRL_SKIP_HALF_EN
  assign second_wr = |sel_q[1:0];
`else
  assign second_wr = 1'b1;
`endif

  always_comb begin
    nxt_state = state;
    nxt_half  = half;
    nxt_cnt   = cnt + 4'd1;
    abort_any = abort | ~req;
    case (state)
      S_IDLE: begin
        nxt_cnt = '0;
        if (req) begin
          if (!wb_we_i) begin
            nxt_state = S_RD;
            nxt_half  = 1'b0;
          end else begin
`ifdef SRAM_CTRL_SKIP_HALF_EN
            if (|wb_sel_i[3:2]) begin
              nxt_state = S_WSETUP;
              nxt_half  = 1'b0;
            end else if (|wb_sel_i[1:0]) begin
              nxt_state = S_WSETUP;
              nxt_half  = 1'b1;
            end else begin
              nxt_state = S_ACK;
            end
`else
            nxt_state = S_WSETUP;
            nxt_half  = 1'b0;
`endif
          end
        end
      end
      S_RD: begin
        if (cnt == RD_LAST) begin
          nxt_cnt = '0;
          if (abort_any) begin
            nxt_state = S_IDLE;
          end else if (!half) begin
            nxt_half = 1'b1;
          end else begin
            nxt_state = S_ACK;
          end
        end
      end
      S_WSETUP: begin
        // No WE_ pulse has started yet, so an abort here leaves the SRAM untouched.
        nxt_cnt   = '0;
        nxt_state = abort_any ? S_IDLE : S_WPULSE;
      end
      S_WPULSE: begin
        if (cnt == WP_LAST) begin
          nxt_cnt   = '0;
          nxt_state = S_WHOLD;
        end
      end
      S_WHOLD: begin
        nxt_cnt = '0;
        if (abort_any) begin
          nxt_state = S_IDLE;
        end else if (!half && second_wr) begin
          nxt_state = S_WSETUP;
          nxt_half  = 1'b1;
        end else begin
          nxt_state = S_ACK;
        end
      end
      S_ACK: begin
        nxt_cnt   = '0;
        nxt_state = S_IDLE;
      end
      default: begin
        nxt_cnt   = '0;
        nxt_state = S_IDLE;
      end
    endcase
  end

  assign nxt_wr = (nxt_state == S_WSETUP) || (nxt_state == S_WPULSE) ||
                  (nxt_state == S_WHOLD);

  assign enter_acc = ((nxt_state == S_RD) || (nxt_state == S_WSETUP)) &&
                     ((nxt_state != state) || (nxt_half != half));

  // SRAM pins are registered from the next state so WE_ cannot glitch.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= S_IDLE;
      half        <= 1'b0;
      cnt         <= '0;
      abort       <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      sram_a_o    <= '0;
      sram_ce_n_o <= 1'b1;
      sram_oe_n_o <= 1'b1;
      sram_we_n_o <= 1'b1;
      sram_lb_n_o <= 1'b1;
      sram_ub_n_o <= 1'b1;
      drive       <= 1'b0;
      dout        <= '0;
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= '0;
    end else begin
      state <= nxt_state;
      half  <= nxt_half;
      cnt   <= nxt_cnt;
      abort <= (state != S_IDLE) && (nxt_state != S_IDLE) && abort_any;

      if (state == S_IDLE && req) begin
        adr_q <= wb_adr_i[18:2];
        dat_q <= wb_dat_i;
        sel_q <= wb_sel_i;
      end

      if (enter_acc)
        sram_a_o <= {cur_adr, nxt_half};

      sram_ce_n_o <= ~((nxt_state == S_RD) || nxt_wr);
      sram_oe_n_o <= ~(nxt_state == S_RD);
      sram_we_n_o <= ~(nxt_state == S_WPULSE);

      if (nxt_state == S_RD) begin
        sram_ub_n_o <= 1'b0;
        sram_lb_n_o <= 1'b0;
      end else if (nxt_wr) begin
        sram_ub_n_o <= ~nxt_lanes[1];
        sram_lb_n_o <= ~nxt_lanes[0];
      end else begin
        sram_ub_n_o <= 1'b1;
        sram_lb_n_o <= 1'b1;
      end

      drive <= nxt_wr;
      if (nxt_wr)
        dout <= nxt_wdat;

      wb_ack_o <= (nxt_state == S_ACK);

      if (rd_done) begin
        if (half)
          wb_dat_o[15:0]  <= sram_io;
        else
          wb_dat_o[31:16] <= sram_io;
      end
    end
  end

  assign sram_io = drive ? dout : 16'hzzzz;

endmodule

// File: tb/tb_sram_wb_ctrl.sv
// Scoreboarded bench: two controllers (W=1 and W=3), each wired to a behavioural 256K x 16 SRAM.
module tb_sram_wb_ctrl;

  typedef struct {
    logic        rd;
    logic [31:0] dat;
    int          start;
    int          lat;
    int          we_tot;
    int          oe_tot;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wb_adr = '0;
  logic [31:0] wb_dat = '0;
  logic [3:0]  wb_sel = '0;
  logic        wb_we = 1'b0;
  logic [1:0]  cyc = '0;
  logic [1:0]  stb = '0;
  logic [1:0]  ack;
  logic [31:0] dat_o [2];
  logic [17:0] a [2];
  logic [1:0]  ce_n, oe_n, we_n, lb_n, ub_n;
  wire  [15:0] io0, io1;

  logic [15:0] mem [2][262144];

  int   cyc_cnt = 0;
  int   we_cnt [2] = '{0, 0};
  int   oe_cnt [2] = '{0, 0};
  int   ack_cnt [2] = '{0, 0};
  logic overlap [2] = '{1'b0, 1'b0};
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sb0 [$];
  exp_t sb1 [$];

`ifdef SRAM_CTRL_SKIP_HALF_EN
  localparam int BYTE_LAT = 4;
  localparam int BYTE_WE  = 1;
`else
  localparam int BYTE_LAT = 7;
  localparam int BYTE_WE  = 2;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  sram_wb_ctrl #(.WAIT_CYCLES(1)) u_w1 (
    .clk_i(clk), .rst_n_i(rst_n),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(dat_o[0]), .wb_sel_i(wb_sel),
    .wb_we_i(wb_we), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_ack_o(ack[0]),
    .sram_a_o(a[0]), .sram_io(io0), .sram_ce_n_o(ce_n[0]), .sram_oe_n_o(oe_n[0]),
    .sram_we_n_o(we_n[0]), .sram_lb_n_o(lb_n[0]), .sram_ub_n_o(ub_n[0])
  );

  sram_wb_ctrl #(.WAIT_CYCLES(3)) u_w3 (
    .clk_i(clk), .rst_n_i(rst_n),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(dat_o[1]), .wb_sel_i(wb_sel),
    .wb_we_i(wb_we), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_ack_o(ack[1]),
    .sram_a_o(a[1]), .sram_io(io1), .sram_ce_n_o(ce_n[1]), .sram_oe_n_o(oe_n[1]),
    .sram_we_n_o(we_n[1]), .sram_lb_n_o(lb_n[1]), .sram_ub_n_o(ub_n[1])
  );

  assign io0 = (!ce_n[0] && !oe_n[0]) ? mem[0][a[0]] : 16'hzzzz;
  assign io1 = (!ce_n[1] && !oe_n[1]) ? mem[1][a[1]] : 16'hzzzz;

  always @(negedge clk) begin
    if (!ce_n[0] && !we_n[0]) begin
      if (!ub_n[0]) mem[0][a[0]][15:8] <= io0[15:8];
      if (!lb_n[0]) mem[0][a[0]][7:0]  <= io0[7:0];
    end
    if (!ce_n[1] && !we_n[1]) begin
      if (!ub_n[1]) mem[1][a[1]][15:8] <= io1[15:8];
      if (!lb_n[1]) mem[1][a[1]][7:0]  <= io1[7:0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Monitor: SRAM strobe bookkeeping plus scoreboard pop on every ack.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      int   qs;
      if (!we_n[i]) we_cnt[i]++;
      if (!oe_n[i]) oe_cnt[i]++;
      if (!we_n[i] && !oe_n[i]) overlap[i] = 1'b1;
      if (ack[i]) begin
        ack_cnt[i]++;
        qs = (i == 0) ? sb0.size() : sb1.size();
        if (qs == 0) begin
          chk("unexpected_ack", 32'(i + 1), 32'd0);
        end else begin
          if (i == 0) e = sb0.pop_front();
          else        e = sb1.pop_front();
          chk("ack_latency", 32'(cyc_cnt - e.start), 32'(e.lat));
          chk("we_low_cycles", 32'(we_cnt[i]), 32'(e.we_tot));
          chk("oe_low_cycles", 32'(oe_cnt[i]), 32'(e.oe_tot));
          chk("oe_we_overlap", {31'd0, overlap[i]}, 32'd0);
          if (e.rd) chk("read_data", dat_o[i], e.dat);
        end
      end
    end
  end

  task automatic issue(input int i, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] exp_dat, input int lat,
                       input int nwe, input int noe);
    exp_t e;
    bit   got;
    @(posedge clk); #1;
    wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_we = we;
    cyc[i] = 1'b1; stb[i] = 1'b1;
    e.rd = !we; e.dat = exp_dat; e.start = cyc_cnt; e.lat = lat;
    e.we_tot = we_cnt[i] + nwe; e.oe_tot = oe_cnt[i] + noe;
    if (i == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 64 && !got; k++) begin
      @(posedge clk); #1;
      if (ack[i]) got = 1'b1;
    end
    if (!got) begin
      chk("ack_timeout", 32'd0, 32'd1);
      cyc[i] = 1'b0; stb[i] = 1'b0;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    cyc = '0; stb = '0;
  endtask

  task automatic wait_we_low(input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk); #1;
      if (!we_n[0]) got = 1'b1;
    end
    chk(name, {31'd0, got}, 32'd1);
  endtask

  initial begin
    int base_ack, base_we;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ack", {31'd0, ack[i]}, 32'd0);
      chk("rst_dat_o", dat_o[i], 32'd0);
      chk("rst_addr", {14'd0, a[i]}, 32'd0);
      chk("rst_ctrl_n", {27'd0, ce_n[i], oe_n[i], we_n[i], lb_n[i], ub_n[i]}, 32'h1F);
    end
    @(negedge clk) rst_n = 1'b1;

    issue(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'd0, 7, 2, 0);
    issue(0, 1'b0, 32'h0000_0010, 32'd0, 4'hF, 32'hDEAD_BEEF, 5, 0, 4);
    idle();
    chk("mem_hw8", {16'd0, mem[0][8]}, 32'h0000_DEAD);
    chk("mem_hw9", {16'd0, mem[0][9]}, 32'h0000_BEEF);

    issue(0, 1'b1, 32'h0000_0011, 32'h0055_0000, 4'b0100, 32'd0, BYTE_LAT, BYTE_WE, 0);
    issue(0, 1'b0, 32'h0000_0011, 32'd0, 4'h0, 32'hDE55_BEEF, 5, 0, 4);
    idle();

    issue(1, 1'b1, 32'h0007_FFFC, 32'hCAFE_F00D, 4'hF, 32'd0, 11, 6, 0);
    idle();
    issue(1, 1'b0, 32'h0007_FFFC, 32'd0, 4'hF, 32'hCAFE_F00D, 9, 0, 8);
    idle();
    chk("top_addr", {14'd0, a[1]}, 32'h0003_FFFF);
    chk("mem_top_hi", {16'd0, mem[1][18'h3FFFE]}, 32'h0000_CAFE);
    chk("mem_top_lo", {16'd0, mem[1][18'h3FFFF]}, 32'h0000_F00D);

    issue(0, 1'b1, 32'h0000_0020, 32'hAAAA_5555, 4'hF, 32'd0, 7, 2, 0);
    idle();
    base_ack = ack_cnt[0];
    base_we  = we_cnt[0];
    @(posedge clk); #1;
    wb_adr = 32'h0000_0020; wb_dat = 32'h1111_2222; wb_sel = 4'hF; wb_we = 1'b1;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    wait_we_low("abort_we_seen");
    cyc[0] = 1'b0; stb[0] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_ack", 32'(ack_cnt[0]), 32'(base_ack));
    chk("abort_we_pulse_done", 32'(we_cnt[0]), 32'(base_we + 1));
    chk("abort_half0", {16'd0, mem[0][16]}, 32'h0000_1111);
    chk("abort_half1", {16'd0, mem[0][17]}, 32'h0000_5555);
    chk("abort_idle_ce", {31'd0, ce_n[0]}, 32'd1);

    @(posedge clk); #1;
    wb_adr = 32'h0000_0040; wb_dat = 32'h0123_4567; wb_sel = 4'hF; wb_we = 1'b1;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    wait_we_low("reset_we_seen");
    rst_n = 1'b0;
    #1;
    chk("reset_we_n", {31'd0, we_n[0]}, 32'd1);
    chk("reset_ce_n", {31'd0, ce_n[0]}, 32'd1);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    issue(0, 1'b1, 32'h0000_0040, 32'h0123_4567, 4'hF, 32'd0, 7, 2, 0);
    issue(0, 1'b0, 32'h0000_0040, 32'd0, 4'hF, 32'h0123_4567, 5, 0, 4);
    idle();
    repeat (4) @(posedge clk);
    chk("sb0_drained", 32'(sb0.size()), 32'd0);
    chk("sb1_drained", 32'(sb1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
